group_sched: RTL and testbench

GROUP_SCHED -- requirements
Module: group_sched

---
 rtl/group_sched_if.sv | 24 ++
 rtl/group_sched.sv | 80 ++++++++
 tb/tb_group_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/group_sched_if.sv
// group_sched_if: start/source/grouping-datapath signal bundle for group_sched
interface group_sched_if #(
    parameter int WIDTH_D = 27
);
    logic               i_start;
    logic               i_src_valid;
    logic [WIDTH_D-1:0] i_src_data;
    logic               o_src_ready;
    logic               o_vsync;
    logic               o_hsync;
    logic               o_reuse;
    logic               o_valid;
    logic [WIDTH_D-1:0] o_tdata;
    logic               o_busy;
    logic               o_done;
    modport master (
        output i_start, i_src_valid, i_src_data,
        input  o_src_ready, o_vsync, o_hsync, o_reuse, o_valid, o_tdata, o_busy, o_done
    );
    modport slave (
        input  i_start, i_src_valid, i_src_data,
        output o_src_ready, o_vsync, o_hsync, o_reuse, o_valid, o_tdata, o_busy, o_done
    );
endinterface

// File: rtl/group_sched.sv
// group_sched: frame/row sequencer feeding SIZE rows of SIZE*CHANNEL beats, then one flush row
module group_sched #(
    parameter int WIDTH_D = 27,
    parameter int SIZE    = 56,
    parameter int CHANNEL = 64,
    parameter int PADWAIT = 21
) (
    input logic          i_sclk,
    input logic          i_rstn,
    group_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, VSYNC, HSYNC, DATA, PAD, FLUSH, DONE} state_t;
    localparam int BEATS = SIZE * CHANNEL;
    localparam int BW = $clog2(BEATS - 1) + 1;
    localparam int RW = $clog2(SIZE) + 1;
    localparam int PW = $clog2(PADWAIT - 1) + 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [RW-1:0] ROW_FLUSH = RW'(SIZE);
    localparam logic [PW-1:0] PAD_LAST  = PW'(PADWAIT - 1);
    state_t          state, state_nx;
    logic [BW-1:0]   beat_cnt;
    logic [RW-1:0]   row_cnt;
    logic [PW-1:0]   pad_cnt;
    logic            beat_last, pad_last, flush_row, hs;
    assign beat_last = beat_cnt == BEAT_LAST;
    assign pad_last  = pad_cnt == PAD_LAST;
    assign flush_row = row_cnt == ROW_FLUSH;
    assign hs        = state == DATA && bus.i_src_valid;
    // state register
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nx;
    end
    // beat counts handshakes in DATA and plain cycles in FLUSH; row advances as each PAD ends
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            beat_cnt <= '0;
            row_cnt  <= '0;
            pad_cnt  <= '0;
        end else begin
            if (state == VSYNC) row_cnt <= '0;
            else if (state == PAD && pad_last) row_cnt <= row_cnt + RW'(1);
            if (hs || state == FLUSH) beat_cnt <= beat_last ? '0 : beat_cnt + BW'(1);
            if (state == PAD) pad_cnt <= pad_last ? '0 : pad_cnt + PW'(1);
        end
    end
    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.i_start ? VSYNC : IDLE;
            VSYNC:   state_nx = HSYNC;
            HSYNC:   state_nx = flush_row ? FLUSH : DATA;
            DATA:    state_nx = hs && beat_last ? PAD : DATA;
            FLUSH:   state_nx = beat_last ? PAD : FLUSH;
            PAD:     state_nx = pad_last ? (flush_row ? DONE : HSYNC) : PAD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // control outputs decoded from the state register only
    always_comb begin
        bus.o_src_ready = state == DATA;
        bus.o_vsync     = state == VSYNC;
        bus.o_hsync     = state == HSYNC;
        bus.o_reuse     = (state == HSYNC || state == FLUSH || state == PAD) && flush_row;
        bus.o_busy      = state != IDLE;
        bus.o_done      = state == DONE;
    end
    // accepted word is presented one cycle after its handshake; tdata holds otherwise
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_valid <= 1'b0;
            bus.o_tdata <= '0;
        end else begin
            bus.o_valid <= hs;
            if (hs) bus.o_tdata <= bus.i_src_data;
        end
    end
endmodule

// File: tb/tb_group_sched.sv
// tb_group_sched: self-checking bench for group_sched with a frame-schedule reference model
module tb_group_sched;
    localparam int W = 27, S = 4, C = 2, P = 3, BEATS = S * C, NMAX = 400;
    typedef struct {
        int         cyc;
        logic [5:0] ctl;
    } vec_t;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    group_sched_if #(.WIDTH_D(W)) bus();
    group_sched #(.WIDTH_D(W), .SIZE(S), .CHANNEL(C), .PADWAIT(P)) u_dut (
        .i_sclk(clk),
        .i_rstn(rstn),
        .bus(bus)
    );
    int checks = 0;
    int failures = 0;
    int vcount;
    logic         v[NMAX];
    logic [W-1:0] d[NMAX];
    logic [6:0]   e_ctl[NMAX];
    logic [W-1:0] e_dat[NMAX];
    logic [5:0]   obs[NMAX];
    vec_t         tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // expected per-cycle {vsync,hsync,reuse,busy,done,ready,valid} for a start pulse in cycle 0
    function automatic int build_model();
        int t = 1;
        for (int i = 0; i < NMAX; i++) begin
            e_ctl[i] = '0;
            e_dat[i] = '0;
        end
        e_ctl[t][6] = 1'b1;
        t++;
        for (int r = 0; r <= S; r++) begin
            e_ctl[t][5] = 1'b1;
            e_ctl[t][4] = (r == S);
            t++;
            if (r < S) begin
                int n = 0;
                while (n < BEATS && t < NMAX - 40) begin
                    e_ctl[t][1] = 1'b1;
                    if (v[t]) begin
                        n++;
                        e_ctl[t+1][0] = 1'b1;
                        e_dat[t+1] = d[t];
                    end
                    t++;
                end
            end else begin
                for (int k = 0; k < BEATS; k++) begin
                    e_ctl[t][4] = 1'b1;
                    t++;
                end
            end
            for (int k = 0; k < P; k++) begin
                e_ctl[t][4] = (r == S);
                t++;
            end
        end
        e_ctl[t][2] = 1'b1;
        for (int i = 1; i <= t; i++) e_ctl[i][3] = 1'b1;
        return t;
    endfunction

    task automatic run_frame(input int len);
        logic [6:0] act;
        vcount = 0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            act = {bus.o_vsync, bus.o_hsync, bus.o_reuse, bus.o_busy, bus.o_done, bus.o_src_ready, bus.o_valid};
            obs[c] = act[6:1];
            check($sformatf("ctl c%0d", c), act, e_ctl[c]);
            if (e_ctl[c][0]) check($sformatf("tdata c%0d", c), bus.o_tdata, e_dat[c]);
            if (bus.o_valid) vcount++;
            bus.i_start     = (c == 0);
            bus.i_src_valid = v[c];
            bus.i_src_data  = d[c];
        end
        bus.i_start     = 1'b0;
        bus.i_src_valid = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < NMAX; i++) begin
            d[i] = W'($urandom);
            v[i] = (mode == 0) ? 1'b1 : ((i % 4 == 0) || ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        int len;
        int done_at;
        bit idle_seen;
        tbl = '{'{0, 6'b000000}, '{1, 6'b100100}, '{2, 6'b010100}, '{3, 6'b000101},
                '{10, 6'b000101}, '{11, 6'b000100}, '{14, 6'b010100}, '{50, 6'b011100},
                '{51, 6'b001100}, '{61, 6'b001100}, '{62, 6'b000110}, '{63, 6'b000000}};
        bus.i_start = 1'b0;
        bus.i_src_valid = 1'b0;
        bus.i_src_data = '0;
        repeat (2) @(negedge clk);
        check("reset ctl", {bus.o_vsync, bus.o_hsync, bus.o_reuse, bus.o_busy, bus.o_done, bus.o_src_ready, bus.o_valid}, 0);
        check("reset tdata", bus.o_tdata, 0);
        rstn = 1'b1;
        // always-valid frame, plus fixed timing table
        fill(0);
        len = build_model() + 2;
        run_frame(len);
        check("s1 valid count", vcount, 32);
        for (int i = 0; i < 12; i++) check($sformatf("s1 table c%0d", tbl[i].cyc), obs[tbl[i].cyc], tbl[i].ctl);
        // five-cycle source drop mid row 1
        fill(0);
        for (int i = 18; i <= 22; i++) v[i] = 1'b0;
        len = build_model() + 2;
        run_frame(len);
        check("s2 valid count", vcount, 32);
        done_at = -1;
        for (int i = 0; i < len; i++) if (obs[i][1]) done_at = i;
        check("s2 done cycle", done_at, 67);
        // start held high: back-to-back frames, VSYNC only one cycle after each IDLE
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            check($sformatf("s3 vsync c%0d", c), bus.o_vsync, (c == 1 || c == 64 || c == 127));
            bus.i_start = 1'b1;
            bus.i_src_valid = 1'b1;
        end
        bus.i_start = 1'b0;
        idle_seen = 1'b0;
        for (int c = 0; c < 100 && !idle_seen; c++) begin
            @(negedge clk);
            idle_seen = !bus.o_busy;
        end
        check("s3 return to idle", idle_seen, 1);
        bus.i_src_valid = 1'b0;
        // reset during row 2 DATA
        fill(0);
        void'(build_model());
        run_frame(31);
        #1 rstn = 1'b0;
        #1;
        check("s4 async reset ctl", {bus.o_vsync, bus.o_hsync, bus.o_reuse, bus.o_busy, bus.o_done, bus.o_src_ready, bus.o_valid}, 0);
        check("s4 async reset tdata", bus.o_tdata, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("s4 held reset done/busy %0d", c), {bus.o_done, bus.o_busy}, 0);
        end
        rstn = 1'b1;
        fill(1);
        len = build_model() + 2;
        run_frame(len);
        check("s4 valid count", vcount, 32);
        // random-valid frames against the schedule model
        for (int f = 0; f < 3; f++) begin
            fill(1);
            len = build_model() + 2;
            run_frame(len);
            check($sformatf("rand%0d valid count", f), vcount, 32);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
